// File: rtl/conv_encoder_tx.sv
// rtl/conv_encoder_tx.sv - rate-1/2 feed-forward convolutional encoder with zero-tail frame termination
// Optional feature macro: CONV_ENC_ERRINJ_EN (adds err_mask/err_idx symbol corruption ports)

module conv_encoder_tx #(
  parameter int         K      = 3,
  parameter logic [7:0] G0_OCT = 8'o07,
  parameter logic [7:0] G1_OCT = 8'o05,
  parameter int         FCW    = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_bit,
  input  logic           in_last,
  output logic           sym_valid,
  input  logic           sym_ready,
  output logic [1:0]     sym,
  output logic           sym_last,
  output logic [FCW-1:0] frame_count
`ifdef CONV_ENC_ERRINJ_EN
  ,
  input  logic [1:0]     err_mask,
  input  logic [7:0]     err_idx
`endif
);

  localparam int M  = K - 1;
  localparam int TW = $clog2(K);
  localparam logic [K-1:0] G0 = G0_OCT[K-1:0];
  localparam logic [K-1:0] G1 = G1_OCT[K-1:0];

  typedef enum logic {ST_DATA, ST_TAIL} st_t;

  st_t            st_q, st_d;
  logic [M-1:0]   state_q, state_d;
  logic [TW-1:0]  tail_cnt_q, tail_cnt_d;
  logic           sym_valid_q, sym_valid_d;
  logic [1:0]     sym_q, sym_d;
  logic           sym_last_q, sym_last_d;
  logic [FCW-1:0] frame_count_q, frame_count_d;
`ifdef CONV_ENC_ERRINJ_EN
  logic [7:0]     sym_cnt_q, sym_cnt_d;
`endif

  logic           slot;
  logic           produce;
  logic           b;
  logic           last_sym;
  logic [K-1:0]   sr;
  logic [1:0]     code;
  logic [1:0]     mask;

  assign sym_valid   = sym_valid_q;
  assign sym         = sym_q;
  assign sym_last    = sym_last_q;
  assign frame_count = frame_count_q;

  // FSM next state, encoder datapath and output-register load/drain decisions
  always_comb begin
    st_d          = st_q;
    state_d       = state_q;
    tail_cnt_d    = tail_cnt_q;
    sym_valid_d   = sym_valid_q;
    sym_d         = sym_q;
    sym_last_d    = sym_last_q;
    frame_count_d = frame_count_q;
    in_ready      = 1'b0;
    produce       = 1'b0;
    b             = 1'b0;
    last_sym      = 1'b0;
    mask          = 2'b00;
    // The output register can accept a new symbol when empty or draining this cycle.
    slot          = !sym_valid_q || sym_ready;

    case (st_q)
      ST_DATA: begin
        in_ready = slot;
        if (in_valid && slot) begin
          produce = 1'b1;
          b       = in_bit;
          if (in_last) begin
            st_d       = ST_TAIL;
            tail_cnt_d = '0;
          end
        end
      end
      ST_TAIL: begin
        // Flush M zeros; the source keeps its next bit until we return to ST_DATA.
        if (slot) begin
          produce    = 1'b1;
          b          = 1'b0;
          tail_cnt_d = tail_cnt_q + TW'(1);
          if (tail_cnt_q == TW'(M - 1)) begin
            last_sym = 1'b1;
            st_d     = ST_DATA;
          end
        end
      end
      default: st_d = ST_DATA;
    endcase

    sr   = {state_q, b};
    code = {^(sr & G0), ^(sr & G1)};

`ifdef CONV_ENC_ERRINJ_EN
    sym_cnt_d = sym_cnt_q;
    if (produce) begin
      if (sym_cnt_q == err_idx) mask = err_mask;
      if (last_sym)                sym_cnt_d = 8'd0;
      else if (sym_cnt_q != 8'hff) sym_cnt_d = sym_cnt_q + 8'd1;
    end
`endif

    if (produce) begin
      state_d     = sr[K-2:0];
      sym_valid_d = 1'b1;
      sym_d       = code ^ mask;
      sym_last_d  = last_sym;
    end else if (sym_ready) begin
      sym_valid_d = 1'b0;
    end

    if (sym_valid_q && sym_ready && sym_last_q)
      frame_count_d = frame_count_q + FCW'(1);
  end

  // State registers with synchronous reset; reset discards any partial frame and pending symbol
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q          <= ST_DATA;
      state_q       <= '0;
      tail_cnt_q    <= '0;
      sym_valid_q   <= 1'b0;
      sym_q         <= 2'b00;
      sym_last_q    <= 1'b0;
      frame_count_q <= '0;
`ifdef CONV_ENC_ERRINJ_EN
      sym_cnt_q     <= 8'd0;
`endif
    end else begin
      st_q          <= st_d;
      state_q       <= state_d;
      tail_cnt_q    <= tail_cnt_d;
      sym_valid_q   <= sym_valid_d;
      sym_q         <= sym_d;
      sym_last_q    <= sym_last_d;
      frame_count_q <= frame_count_d;
`ifdef CONV_ENC_ERRINJ_EN
      sym_cnt_q     <= sym_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_conv_encoder_tx.sv
// tb/tb_conv_encoder_tx.sv - directed self-checking bench for conv_encoder_tx (K=3, 7/5, FCW=2)

module tb_conv_encoder_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_bit, in_last;
  logic       sym_valid, sym_ready, sym_last;
  logic [1:0] sym;
  logic [1:0] frame_count;
`ifdef CONV_ENC_ERRINJ_EN
  logic [1:0] err_mask;
  logic [7:0] err_idx;
`endif

  int errors = 0;
  int checks = 0;

  // Scenario 1: bits 1,1,1,1,0,0,0,0 -> 11,01,10,10,01,11,00,00 + tail 00,00 (symbol 0 in LSBs)
  localparam logic [63:0] S1  = 64'({2'b00,2'b00,2'b00,2'b00,2'b11,2'b01,2'b10,2'b10,2'b01,2'b11});
  localparam logic [31:0] L1  = 32'b10_0000_0000;
  // Frames {1} and {0,1}: 11,10,11 (last) then 00,11,10,11 (last)
  localparam logic [63:0] S3  = 64'({2'b11,2'b10,2'b11,2'b00,2'b11,2'b10,2'b11});
  localparam logic [31:0] L3  = 32'b100_0100;
`ifdef CONV_ENC_ERRINJ_EN
  localparam logic [63:0] S1E = 64'({2'b00,2'b00,2'b00,2'b00,2'b11,2'b01,2'b10,2'b00,2'b01,2'b11});
`endif

  always #5 clk = ~clk;

  conv_encoder_tx #(.K(3), .G0_OCT(8'o07), .G1_OCT(8'o05), .FCW(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_bit      (in_bit),
    .in_last     (in_last),
    .sym_valid   (sym_valid),
    .sym_ready   (sym_ready),
    .sym         (sym),
    .sym_last    (sym_last),
    .frame_count (frame_count)
`ifdef CONV_ENC_ERRINJ_EN
    ,
    .err_mask    (err_mask),
    .err_idx     (err_idx)
`endif
  );

  // Drives bits and sym_ready (mode 0: always ready, mode 1: 1,0,0 repeating) and checks the stream
  task automatic run_frames(input string tag, input logic [31:0] bits, input logic [31:0] lasts,
                            input int nbits, input logic [63:0] exp_s, input logic [31:0] exp_l,
                            input int nsym, input int mode);
    int bi, ri, cyc;
    logic held_v, tail, exp_rdy;
    logic [1:0] held_s;
    bi = 0; ri = 0; cyc = 0; held_v = 1'b0; tail = 1'b0; held_s = 2'b00;
    while (ri < nsym && cyc < 200) begin
      @(negedge clk);
      if (held_v) begin
        checks++;
        if (sym_valid !== 1'b1 || sym !== held_s) begin
          errors++;
          $display("FAIL %s hold cyc=%0d: valid=%b sym=%b, required valid=1 sym=%b", tag, cyc, sym_valid, sym, held_s);
        end
      end
      if (sym_valid && sym_last) tail = 1'b0;
      sym_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      in_valid  = (bi < nbits);
      in_bit    = bits[bi];
      in_last   = lasts[bi];
      #1;
      exp_rdy = !tail && (!sym_valid || sym_ready);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL %s in_ready cyc=%0d: got %b, required %b", tag, cyc, in_ready, exp_rdy);
      end
      if (sym_valid && sym_ready) begin
        checks++;
        if (sym !== exp_s[2*ri +: 2] || sym_last !== exp_l[ri]) begin
          errors++;
          $display("FAIL %s symbol %0d: got sym=%b last=%b, required sym=%b last=%b",
                   tag, ri, sym, sym_last, exp_s[2*ri +: 2], exp_l[ri]);
        end
        ri++;
      end
      if (in_valid && in_ready) begin
        if (in_last) tail = 1'b1;
        bi++;
      end
      held_v = sym_valid && !sym_ready;
      held_s = sym;
      @(posedge clk);
      cyc++;
    end
    checks++;
    if (ri < nsym) begin
      errors++;
      $display("FAIL %s timeout: got %0d symbols, required %0d", tag, ri, nsym);
    end
  endtask

  task automatic check_fc(input string tag, input logic [1:0] exp_fc);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++;
    if (frame_count !== exp_fc) begin
      errors++;
      $display("FAIL %s frame_count: got %0d, required %0d", tag, frame_count, exp_fc);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0; sym_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (sym_valid !== 1'b0 || sym !== 2'b00 || sym_last !== 1'b0 || frame_count !== 2'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: valid=%b sym=%b last=%b fc=%0d in_ready=%b, required 0 00 0 0 1",
               sym_valid, sym, sym_last, frame_count, in_ready);
    end
  endtask

  task automatic test_single_frame();
    run_frames("single_frame", 32'b0000_1111, 32'b1000_0000, 8, S1, L1, 10, 0);
    check_fc("single_frame", 2'd1);
  endtask

  task automatic test_stall();
    run_frames("stall", 32'b0000_1111, 32'b1000_0000, 8, S1, L1, 10, 1);
    check_fc("stall", 2'd2);
  endtask

  task automatic test_back_to_back(input logic [1:0] exp_fc);
    run_frames("back_to_back", 32'b101, 32'b101, 3, S3, L3, 7, 0);
    check_fc("back_to_back", exp_fc);
  endtask

  task automatic test_reset_mid();
    run_frames("reset_mid", 32'b0000_1111, 32'b1000_0000, 8, S1, L1, 4, 0);
    @(negedge clk);
    in_valid = 1'b0; sym_ready = 1'b0;
    #1;
    checks++;
    if (sym_valid !== 1'b1 || sym !== 2'b01) begin
      errors++;
      $display("FAIL reset_mid pending: valid=%b sym=%b, required valid=1 sym=01", sym_valid, sym);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (sym_valid !== 1'b0 || frame_count !== 2'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid after: valid=%b fc=%0d in_ready=%b, required 0 0 1", sym_valid, frame_count, in_ready);
    end
    run_frames("reset_mid_resend", 32'b0000_1111, 32'b1000_0000, 8, S1, L1, 10, 0);
    check_fc("reset_mid_resend", 2'd1);
  endtask

`ifdef CONV_ENC_ERRINJ_EN
  task automatic test_errinj();
    err_idx = 8'd2; err_mask = 2'b10;
    run_frames("errinj", 32'b0000_1111, 32'b1000_0000, 8, S1E, L1, 10, 0);
    err_mask = 2'b00;
    run_frames("errinj_clean", 32'b0000_1111, 32'b1000_0000, 8, S1, L1, 10, 0);
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0; sym_ready = 1'b0;
`ifdef CONV_ENC_ERRINJ_EN
    err_mask = 2'b00; err_idx = 8'd0;
`endif
    test_reset();
    test_single_frame();
    test_stall();
    test_reset_mid();
    test_back_to_back(2'd3);
    test_back_to_back(2'd1);
`ifdef CONV_ENC_ERRINJ_EN
    test_errinj();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
